// File: rtl/truth_table_sequencer_pkg.sv
// Shared state encoding and default parameters for the truth-table sequencer.
package truth_table_sequencer_pkg;

  localparam int DEF_N_IN   = 2;
  localparam int DEF_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/truth_table_sequencer_vec_counter.sv
// Vector register for the sweep: synchronous clear, increment enable and an
// all-ones terminal-count flag.
module vec_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;
  assign tc_o  = &cnt_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps vec_out through every input combination, compares two implementations
// of the same boolean function and records mismatches and the first failure.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            res_a,
  input  logic            res_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic [N_IN:0]   mcnt_q, mcnt_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            ffvalid_q, ffvalid_d;
  logic            pass_q, pass_d;

  logic [N_IN-1:0] vec_q;
  logic            vec_tc, vec_clr, vec_en, mis;

  vec_counter #(.W(N_IN)) u_vec (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (vec_clr),
    .en_i  (vec_en),
    .cnt_o (vec_q),
    .tc_o  (vec_tc)
  );

  assign mis = res_a ^ res_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      mcnt_q    <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      mcnt_q    <= mcnt_d;
      ffvec_q   <= ffvec_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    mcnt_d    = mcnt_q;
    ffvec_d   = ffvec_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    vec_clr   = 1'b0;
    vec_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          settle_d  = '0;
          mcnt_d    = '0;
          ffvec_d   = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          vec_clr   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
          vec_clr = 1'b1;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      ST_SAMPLE: begin
        // abort wins over the sample, including the final one
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
          vec_clr = 1'b1;
        end else begin
          if (mis) begin
            mcnt_d = mcnt_q + (N_IN+1)'(1);
            if (!ffvalid_q) begin
              ffvec_d   = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_tc) begin
            state_d = ST_DONE;
            pass_d  = (mcnt_q == '0) && !mis;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            vec_en   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign mismatch_cnt     = mcnt_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule
